// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag indices and FSM encoding shared by the ALU scheduler
package alu_pkg;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] SRA = 4'd4;
    localparam logic [3:0] NOR = 4'd5;

    localparam int CARRY = 3;
    localparam int ZERO  = 2;
    localparam int OVF   = 1;
    localparam int SIGN  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= NOR;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: first request at or after last+1, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - shares one ALU among NUM_REQ requesters, tagged responses
// Optional: ALU_ILLEGAL_OP_CHECK_EN short-circuits opcodes > NOR into an error response.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    input  logic [5*NUM_REQ-1:0]   req_shift,
    output logic [3:0]             alu_opcode,
    output logic [WIDTH-1:0]       alu_input1,
    output logic [WIDTH-1:0]       alu_input2,
    output logic [4:0]             alu_shift,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic [3:0]             alu_flags,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_result,
    output logic [3:0]             resp_flags,
    output logic                   resp_err
);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    last_grant;
    logic               handshake;
    logic               sel_illegal;
    logic [3:0]         sel_opcode;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req      (req_valid),
        .last     (last_grant),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign handshake  = (state == IDLE) && (|req_valid);
    assign sel_opcode = req_opcode[int'(grant_id)*4 +: 4];

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    assign sel_illegal = !is_legal_op(sel_opcode);
`else
    assign sel_illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = sel_illegal ? RESP : ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) ? grant : '0;
        resp_valid = (state == RESP);
    end

    // Illegal ops bypass the ALU entirely, so the op registers keep the previous operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= ID_W'(NUM_REQ-1);
            alu_opcode  <= ADD;
            alu_input1  <= '0;
            alu_input2  <= '0;
            alu_shift   <= '0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            if (handshake) begin
                last_grant <= grant_id;
                if (!sel_illegal) begin
                    alu_opcode <= sel_opcode;
                    alu_input1 <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                    alu_input2 <= req_b[int'(grant_id)*WIDTH +: WIDTH];
                    alu_shift  <= req_shift[int'(grant_id)*5 +: 5];
                end else begin
                    resp_id     <= grant_id;
                    resp_result <= '0;
                    resp_flags  <= '0;
                end
            end
            if (state == ISSUE) begin
                resp_id     <= last_grant;
                resp_result <= alu_result;
                resp_flags  <= alu_flags;
            end
        end
    end

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          err_q <= 1'b0;
        else if (handshake) err_q <= sel_illegal;
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 64-bit ALU (ADD/SUB/AND/OR/SRA/NOR; carry/zero/overflow/sign flags) between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels. Drives the ALU operand/opcode ports from registered state, captures result and flags, returns them on a single tagged response channel.
- Sits between the issue logic of the execution clusters and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand/result width
- ID_W, 2, requester-index width; must equal clog2(NUM_REQ)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester grant/accept; at most one bit high
- req_opcode  input  4*NUM_REQ  packed opcodes; slice i belongs to requester i
- req_a  input  WIDTH*NUM_REQ  packed operand 1
- req_b  input  WIDTH*NUM_REQ  packed operand 2
- req_shift  input  5*NUM_REQ  packed SRA shift amounts
- alu_opcode  output  4  to ALU opcode
- alu_input1  output  WIDTH  to ALU input1
- alu_input2  output  WIDTH  to ALU input2
- alu_shift  output  5  to ALU shiftValue
- alu_result  input  WIDTH  from ALU result
- alu_flags  input  4  from ALU {carry, zero, overflow, sign}
- resp_valid  output  1  response valid
- resp_ready  input  1  response accept
- resp_id  output  ID_W  index of the requester that owns the response
- resp_result  output  WIDTH  captured result
- resp_flags  output  4  captured {carry, zero, overflow, sign}
- resp_err  output  1  illegal opcode (feature-dependent)

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, SRA=4, NOR=5. Values 6..15 are illegal.
- FSM states:
  - IDLE:
    - If any req_valid is high, grant the first set bit searching upward from (last_grant+1) mod NUM_REQ.
    - Assert req_ready for that bit only, combinationally, in the same cycle.
    - On handshake, latch opcode/a/b/shift/id into op registers, set last_grant=id, go to ISSUE.
    - With no valid request, stay in IDLE.
  - ISSUE:
    - alu_* outputs are driven from the op registers.
    - At the clock edge, capture alu_result/alu_flags into the resp registers, then go to RESP.
  - RESP:
    - resp_valid=1; resp_* stay stable until resp_ready.
    - On handshake, go to IDLE. Arbitration restarts the next cycle; there is no back-to-back issue.
- req_ready is 0 outside IDLE. A requester that deasserts valid before it is granted loses nothing.
- Latency: request handshake at cycle T, resp_valid high from T+2. Maximum throughput is one op per 3 cycles.
- alu_* outputs always come from the op registers and hold their value in IDLE and RESP.
- resp_result and resp_flags are passed through unmodified; their widths match the ALU exactly.
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - Op registers 0, so alu_opcode=ADD and operands 0.
  - resp_valid=0, resp_id=0, resp_result=0, resp_flags=0, resp_err=0, req_ready=0.
- Reset mid-operation (ISSUE or RESP): the in-flight op is discarded, no response is produced, and last_grant returns to its reset value.
- Requests that are pending while in RESP are held; they are granted after the response handshake.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_CHECK_EN
- Defined:
  - An accepted request with opcode >5 skips ISSUE and goes IDLE->RESP directly; latency is T+1.
  - resp_err=1, resp_result=0, resp_flags=0.
  - alu_* outputs are not updated.
- Undefined:
  - All opcodes are issued unchanged; resp_err is tied 0.
  - The response carries whatever the ALU returns for that opcode (result 0 for undefined opcodes).

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams ADD..NOR.
  - Flag bit-index constants: CARRY=3, ZERO=2, OVF=1, SIGN=0.
  - FSM state encoding: IDLE, ISSUE, RESP.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin priority picker. Takes the request vector and last_grant; returns a one-hot grant and its encoded index.

Test Plan:
- Reset only -> req_ready=0, resp_valid=0, alu_opcode=0, alu_input1/alu_input2=0.
- Requester 2: ADD a=0xFFFFFFFFFFFFFFFF, b=1 -> resp_valid at T+2; resp_id=2, result=0, flags carry=1, zero=1, overflow=0, sign=0.
- All four requesters valid continuously -> grant order 0,1,2,3,0; each response tagged with the matching resp_id.
- resp_ready held low 5 cycles during RESP -> resp_* stable, req_ready stays 0, next grant the cycle after the handshake.
- SRA a=0x8000000000000000, shift=4, with reset asserted during ISSUE -> no response; after release, requester 0 granted first.
- opcode=9 with ALU_ILLEGAL_OP_CHECK_EN -> resp_err=1, result=0 at T+1. Without the macro -> resp_err=0, result=0 at T+2.
